// File: rtl/ofm_wb_pkg.sv
// rtl/ofm_wb_pkg.sv - shared constants and FSM encoding for the OFM writeback (optional OFMWB_TRAILER_EN)
package ofm_wb_pkg;

  localparam logic [7:0] HDR_MAGIC  = 8'hA5;
  localparam int         SKID_DEPTH = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_FLG,
    S_DAT,
    S_DRAIN
`ifdef OFMWB_TRAILER_EN
    , S_TRL
`endif
  } wb_state_e;

`ifdef OFMWB_TRAILER_EN
  localparam bit        TRL_EN     = 1'b1;
  localparam wb_state_e S_POST_PAY = S_TRL;
`else
  localparam bit        TRL_EN     = 1'b0;
  localparam wb_state_e S_POST_PAY = S_DRAIN;
`endif

endpackage

// File: rtl/ofm_writeback_if.sv
// rtl/ofm_writeback_if.sv - outbound packet stream of the OFM writeback
interface ofm_writeback_if #(
  parameter int DATA_W = 96
);
  logic [DATA_W-1:0] OUT_Dat;
  logic              OUT_Val;
  logic              OUT_Rdy;
  logic              OUT_Last;

  modport master (output OUT_Dat, output OUT_Val, output OUT_Last, input OUT_Rdy);
  modport slave  (input OUT_Dat, input OUT_Val, input OUT_Last, output OUT_Rdy);
endinterface

// File: rtl/ofm_wb_skid.sv
// rtl/ofm_wb_skid.sv - 2-entry FIFO holding stream words with their last flag
module ofm_wb_skid
  import ofm_wb_pkg::*;
#(
  parameter int W = 96
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         push_last,
  input  logic         pop,
  output logic [1:0]   count,
  output logic         valid,
  output logic [W-1:0] dat,
  output logic         last
);

  logic [W:0] mem [SKID_DEPTH];
  logic       wptr;
  logic       rptr;

  // Storage and pointers; the producer's credit check guarantees no push when full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wptr] <= {push_last, push_dat};
        wptr      <= ~wptr;
      end
      if (pop) begin
        rptr <= ~rptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign valid       = (count != 2'd0);
  assign {last, dat} = mem[rptr];

endmodule

// File: rtl/ofm_writeback.sv
// rtl/ofm_writeback.sv - drains one tile's sparse OFM as header/flag/data packet (optional OFMWB_TRAILER_EN)
module ofm_writeback
  import ofm_wb_pkg::*;
#(
  parameter int DATA_W = 96,
  parameter int OFM_AW = 10,
  parameter int FLG_AW = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               Start,
  input  logic [FLG_AW-1:0]  FlgBase,
  input  logic [FLG_AW:0]    FlgCnt,
  input  logic [OFM_AW-1:0]  DatBase,
  input  logic [OFM_AW:0]    DatCnt,
  output logic               GBFFLGOFM_EnRd,
  output logic [FLG_AW-1:0]  GBFFLGOFM_AddrRd,
  input  logic [DATA_W-1:0]  GBFFLGOFM_DatRd,
  output logic               GBFOFM_EnRd,
  output logic [OFM_AW-1:0]  GBFOFM_AddrRd,
  input  logic [DATA_W-1:0]  GBFOFM_DatRd,
  ofm_writeback_if.master    out_if,
  output logic               Busy,
  output logic               Done
);

  localparam int CNT_W = ((OFM_AW > FLG_AW) ? OFM_AW : FLG_AW) + 1;

  wb_state_e         state, state_nxt;
  logic [FLG_AW-1:0] flg_base;
  logic [FLG_AW:0]   flg_cnt;
  logic [OFM_AW-1:0] dat_base;
  logic [OFM_AW:0]   dat_cnt;
  logic [CNT_W-1:0]  k, k_nxt;
  logic              inflight, inflight_dat, inflight_last;
  logic [1:0]        skid_cnt;
  logic              skid_val, skid_last;
  logic [DATA_W-1:0] skid_dat;
  logic              pop, push, push_last, hdr_last;
  logic [DATA_W-1:0] push_dat, hdr_word, rd_word;
  logic [2:0]        occ;
  logic              credit, k_last_flg, k_last_dat;
  logic              hdr_push, trl_push, rd_flg, rd_dat, rd_last;

  // Occupancy counts the word leaving this cycle so a steady stream keeps 1 word/cycle.
  assign pop        = skid_val && out_if.OUT_Rdy;
  assign occ        = {1'b0, skid_cnt} + {2'b0, inflight} - {2'b0, pop};
  assign credit     = (occ < 3'd2);
  assign k_nxt      = k + CNT_W'(1);
  assign k_last_flg = (k_nxt == CNT_W'(flg_cnt));
  assign k_last_dat = (k_nxt == CNT_W'(dat_cnt));
  assign hdr_last   = !TRL_EN && (flg_cnt == '0) && (dat_cnt == '0);
  assign rd_last    = !TRL_EN && (rd_flg ? (k_last_flg && (dat_cnt == '0)) : k_last_dat);
  assign rd_word    = inflight_dat ? GBFOFM_DatRd : GBFFLGOFM_DatRd;

  // Header word: magic byte on top, both counts packed at the bottom.
  always_comb begin
    hdr_word                      = '0;
    hdr_word[DATA_W-1 -: 8]       = HDR_MAGIC;
    hdr_word[FLG_AW:0]            = flg_cnt;
    hdr_word[FLG_AW+1 +: OFM_AW+1] = dat_cnt;
  end

  // State register, latched job parameters, word counter and read-in-flight tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      flg_base      <= '0;
      flg_cnt       <= '0;
      dat_base      <= '0;
      dat_cnt       <= '0;
      k             <= '0;
      inflight      <= 1'b0;
      inflight_dat  <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && Start) begin
        flg_base <= FlgBase;
        flg_cnt  <= FlgCnt;
        dat_base <= DatBase;
        dat_cnt  <= DatCnt;
      end
      if (state_nxt != state) begin
        k <= '0;
      end else if (rd_flg || rd_dat) begin
        k <= k_nxt;
      end
      inflight      <= rd_flg || rd_dat;
      inflight_dat  <= rd_dat;
      inflight_last <= rd_last;
    end
  end

  // Next-state: each phase advances once its last word has been issued.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (Start) state_nxt = S_HDR;
      S_HDR:   if (credit) state_nxt = (flg_cnt != '0) ? S_FLG :
                                       (dat_cnt != '0) ? S_DAT : S_POST_PAY;
      S_FLG:   if (credit && k_last_flg) state_nxt = (dat_cnt != '0) ? S_DAT : S_POST_PAY;
      S_DAT:   if (credit && k_last_dat) state_nxt = S_POST_PAY;
`ifdef OFMWB_TRAILER_EN
      S_TRL:   if (credit && !inflight) state_nxt = S_DRAIN;
`endif
      S_DRAIN: if (skid_cnt == 2'd0 && !inflight) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Per-state actions: header/trailer pushes, SRAM reads, completion pulse.
  always_comb begin
    hdr_push = 1'b0;
    trl_push = 1'b0;
    rd_flg   = 1'b0;
    rd_dat   = 1'b0;
    Done     = 1'b0;
    case (state)
      S_HDR:   hdr_push = credit;
      S_FLG:   rd_flg   = credit;
      S_DAT:   rd_dat   = credit;
`ifdef OFMWB_TRAILER_EN
      S_TRL:   trl_push = credit && !inflight;
`endif
      S_DRAIN: Done     = (skid_cnt == 2'd0) && !inflight;
      default: ;
    endcase
  end

`ifdef OFMWB_TRAILER_EN
  logic [DATA_W-1:0] acc;

  // Running XOR of payload words as they land in the skid buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (state == S_IDLE && Start) begin
      acc <= '0;
    end else if (inflight) begin
      acc <= acc ^ rd_word;
    end
  end
`endif

  // Skid write source: returning read data, else header or trailer (never coincident).
  always_comb begin
    push      = hdr_push || trl_push || inflight;
    push_dat  = hdr_word;
    push_last = hdr_last;
    if (inflight) begin
      push_dat  = rd_word;
      push_last = inflight_last;
    end
`ifdef OFMWB_TRAILER_EN
    if (trl_push) begin
      push_dat  = acc;
      push_last = 1'b1;
    end
`endif
  end

  ofm_wb_skid #(.W(DATA_W)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_dat  (push_dat),
    .push_last (push_last),
    .pop       (pop),
    .count     (skid_cnt),
    .valid     (skid_val),
    .dat       (skid_dat),
    .last      (skid_last)
  );

  assign GBFFLGOFM_EnRd   = rd_flg;
  assign GBFFLGOFM_AddrRd = flg_base + k[FLG_AW-1:0];
  assign GBFOFM_EnRd      = rd_dat;
  assign GBFOFM_AddrRd    = dat_base + k[OFM_AW-1:0];
  assign out_if.OUT_Val   = skid_val;
  assign out_if.OUT_Dat   = skid_dat;
  assign out_if.OUT_Last  = skid_last;
  assign Busy             = (state != S_IDLE);

endmodule
